mac_serial_seq: RTL and testbench

//  Digit-serial multiply-accumulate unit, the next generation of the bit-serial multiplier.
//  - A arrives LSB-first, D bits per accepted cycle; X is parallel and latched at start.
//  - Each N-bit x M-bit product is added into a guarded accumulator with overflow detect.
//  - Sits in the MAC datapath between the serial operand streamer and the result collector.

---
 rtl/mac_serial_seq.sv | 124 ++++++++++++
 tb/tb_mac_serial_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_serial_seq.sv
// Digit-serial multiply-accumulate: A streams in LSB digit first, X is latched at start.
// Optional MAC_SIGNED_EN: treat A, X and the accumulator as two's complement.
module mac_serial_seq #(
    parameter int N = 32,
    parameter int M = N,
    parameter int D = 1,
    parameter int G = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr_acc,
    input  logic [M-1:0]     X,
    input  logic [D-1:0]     a_in,
    input  logic             a_vld,
    output logic             busy,
    output logic             done,
    output logic [N+M+G-1:0] acc_out,
    output logic             ovf
);

    localparam int W     = N + M + G;
    localparam int PW    = N + M;
    localparam int BEATS = N / D;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW    = $clog2(N) + 1;
    localparam int TW    = D + M + 2;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

`ifdef MAC_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MULT, ACC} state_t;

    state_t               state;
    logic [M-1:0]         xr;
    logic signed [PW-1:0] prod;
    logic [CW-1:0]        cnt;
    logic [SW-1:0]        sh;

    logic signed [D:0]    digit;
    logic signed [M:0]    xr_ext;
    logic signed [TW-1:0] term;
    logic signed [PW-1:0] term_sh;
    logic [W-1:0]         prod_ext;
    logic [W-1:0]         acc_sum;
    logic                 acc_ovf;

    // Overflow of acc + addend: carry-out when unsigned, sign rule when signed.
    function automatic logic add_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b};
        if (SIGNED_MODE)
            return (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return full[W];
    endfunction

    // The top digit's MSB carries negative weight in signed mode.
    always_comb begin
        digit    = {(SIGNED_MODE && (cnt == LAST)) ? a_in[D-1] : 1'b0, a_in};
        xr_ext   = {SIGNED_MODE ? xr[M-1] : 1'b0, xr};
        term     = TW'(digit) * TW'(xr_ext);
        term_sh  = PW'(term) << sh;
        prod_ext = SIGNED_MODE ? W'(prod) : W'($unsigned(prod));
        acc_sum  = acc_out + prod_ext;
        acc_ovf  = add_ovf(acc_out, prod_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc_out <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            sh      <= '0;
            prod    <= '0;
            xr      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xr    <= X;
                        prod  <= '0;
                        cnt   <= '0;
                        sh    <= '0;
                        busy  <= 1'b1;
                        state <= MULT;
                        if (clr_acc) begin
                            acc_out <= '0;
                            ovf     <= 1'b0;
                        end
                    end
                end
                MULT: begin
                    if (a_vld) begin
                        prod <= prod + term_sh;
                        cnt  <= cnt + 1'b1;
                        sh   <= sh + SW'(D);
                        if (cnt == LAST)
                            state <= ACC;
                    end
                end
                ACC: begin
                    acc_out <= acc_sum;
                    ovf     <= ovf | acc_ovf;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_serial_seq.sv
// Bench for mac_serial_seq: three 8x8 instances (D=1/G=4, D=2/G=4, D=1/G=0) against an arithmetic model.
module tb_mac_serial_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start[3];
    logic       clr_acc[3];
    logic       a_vld[3];
    logic [7:0] xv[3];
    logic [1:0] a_in[3];
    logic       busy[3];
    logic       done[3];
    logic       ovf[3];
    logic [19:0] acc0;
    logic [19:0] acc1;
    logic [15:0] acc2;

    mac_serial_seq #(.N(8), .M(8), .D(1), .G(4)) u_d1 (
        .clk(clk), .rst(rst), .start(start[0]), .clr_acc(clr_acc[0]), .X(xv[0]),
        .a_in(a_in[0][0:0]), .a_vld(a_vld[0]), .busy(busy[0]), .done(done[0]),
        .acc_out(acc0), .ovf(ovf[0]));

    mac_serial_seq #(.N(8), .M(8), .D(2), .G(4)) u_d2 (
        .clk(clk), .rst(rst), .start(start[1]), .clr_acc(clr_acc[1]), .X(xv[1]),
        .a_in(a_in[1]), .a_vld(a_vld[1]), .busy(busy[1]), .done(done[1]),
        .acc_out(acc1), .ovf(ovf[1]));

    mac_serial_seq #(.N(8), .M(8), .D(1), .G(0)) u_g0 (
        .clk(clk), .rst(rst), .start(start[2]), .clr_acc(clr_acc[2]), .X(xv[2]),
        .a_in(a_in[2][0:0]), .a_vld(a_vld[2]), .busy(busy[2]), .done(done[2]),
        .acc_out(acc2), .ovf(ovf[2]));

    int n_tests = 0;
    int n_fail  = 0;

    longint m_acc[3];
    bit     m_ovf[3];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dw(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic int wdt(input int k);
        return (k == 2) ? 16 : 20;
    endfunction

    function automatic logic [63:0] get_acc(input int k);
        case (k)
            0:       return 64'(acc0);
            1:       return 64'(acc1);
            default: return 64'(acc2);
        endcase
    endfunction

    function automatic logic [63:0] acc_bits(input int k);
        logic [63:0] mask;
        mask = (64'd1 << wdt(k)) - 64'd1;
        return 64'(m_acc[k]) & mask;
    endfunction

    // Exact product of the two 8-bit operands.
    function automatic longint ref_prod(input logic [7:0] a, input logic [7:0] x);
        int ia, ix;
`ifdef MAC_SIGNED_EN
        ia = $signed(a);
        ix = $signed(x);
`else
        ia = int'(a);
        ix = int'(x);
`endif
        return longint'(ia) * longint'(ix);
    endfunction

    // Accumulator value kept as an integer, wrapped into the W-bit range.
    task automatic model_add(input int k, input logic clr, input longint p);
        longint lim, s;
        lim = longint'(1) << wdt(k);
        if (clr) begin
            m_acc[k] = 0;
            m_ovf[k] = 1'b0;
        end
        s = m_acc[k] + p;
`ifdef MAC_SIGNED_EN
        if (s >= lim / 2) begin
            s = s - lim;
            m_ovf[k] = 1'b1;
        end else if (s < -(lim / 2)) begin
            s = s + lim;
            m_ovf[k] = 1'b1;
        end
`else
        if (s >= lim) begin
            s = s - lim;
            m_ovf[k] = 1'b1;
        end
`endif
        m_acc[k] = s;
    endtask

    // One product on instance k; called at a falling edge, returns at the falling edge of the done cycle.
    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] x, input logic clr,
                          input int max_stall, input int stall_at, input int stall_n, input bit noise);
        int d, beats, cyc, stalls, ns, limit;
        d      = dw(k);
        beats  = 8 / d;
        cyc    = 0;
        stalls = 0;
        start[k]   = 1'b1;
        clr_acc[k] = clr;
        xv[k]      = x;
        a_vld[k]   = noise ? 1'($urandom) : 1'b0;
        a_in[k]    = 2'($urandom);
        @(negedge clk);
        cyc++;
        start[k]   = 1'b0;
        clr_acc[k] = 1'($urandom);
        xv[k]      = noise ? 8'($urandom) : x;
        check_eq("busy_after_start", 64'(busy[k]), 64'd1);
        check_eq("done_after_start", 64'(done[k]), 64'd0);
        for (int b = 0; b < beats; b++) begin
            ns = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
            if (b == stall_at) ns = ns + stall_n;
            for (int s = 0; s < ns; s++) begin
                a_vld[k] = 1'b0;
                a_in[k]  = 2'($urandom);
                start[k] = noise ? 1'($urandom) : 1'b0;
                @(negedge clk);
                cyc++;
                stalls++;
            end
            a_vld[k] = 1'b1;
            a_in[k]  = 2'((int'(a) >> (b * d)) & ((1 << d) - 1));
            start[k] = noise ? 1'($urandom) : 1'b0;
            if (noise) xv[k] = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        a_vld[k] = noise ? 1'($urandom) : 1'b0;
        a_in[k]  = 2'($urandom);
        start[k] = noise ? 1'($urandom) : 1'b0;
        check_eq("busy_in_acc", 64'(busy[k]), 64'd1);
        check_eq("done_in_acc", 64'(done[k]), 64'd0);
        @(negedge clk);
        cyc++;
        a_vld[k] = 1'b0;
        start[k] = 1'b0;
        limit = beats + stalls + 20;
        while (!done[k] && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("done_latency", 64'(cyc), 64'(beats + stalls + 2));
        model_add(k, clr, ref_prod(a, x));
        check_eq("acc", get_acc(k), acc_bits(k));
        check_eq("ovf", 64'(ovf[k]), 64'(m_ovf[k]));
        check_eq("busy_at_done", 64'(busy[k]), 64'd0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start[k]   = 1'b0;
            clr_acc[k] = 1'b0;
            a_vld[k]   = 1'b0;
            xv[k]      = 8'd0;
            a_in[k]    = 2'd0;
            m_acc[k]   = 0;
            m_ovf[k]   = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_busy", 64'(busy[k]), 64'd0);
            check_eq("rst_done", 64'(done[k]), 64'd0);
            check_eq("rst_acc", get_acc(k), 64'd0);
            check_eq("rst_ovf", 64'(ovf[k]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

`ifndef MAC_SIGNED_EN
        run_op(0, 8'd255, 8'd255, 1'b1, 0, -1, 0, 1'b0);
        check_eq("t1_acc", get_acc(0), 64'd65025);
        check_eq("t1_ovf", 64'(ovf[0]), 64'd0);

        run_op(0, 8'd3, 8'd5, 1'b1, 0, -1, 0, 1'b0);
        check_eq("t2_acc_a", get_acc(0), 64'd15);
        run_op(0, 8'd7, 8'd9, 1'b0, 0, -1, 0, 1'b0);
        check_eq("t2_acc_b", get_acc(0), 64'd78);
        run_op(0, 8'd255, 8'd255, 1'b0, 0, -1, 0, 1'b0);
        check_eq("t2_acc_c", get_acc(0), 64'd65103);

        run_op(1, 8'hB4, 8'h37, 1'b1, 0, 2, 2, 1'b0);
        check_eq("t3_acc", get_acc(1), 64'd9900);

        run_op(2, 8'd255, 8'd255, 1'b1, 0, -1, 0, 1'b0);
        run_op(2, 8'd255, 8'd255, 1'b0, 0, -1, 0, 1'b0);
        check_eq("t4_acc", get_acc(2), 64'd64514);
        check_eq("t4_ovf", 64'(ovf[2]), 64'd1);
        run_op(2, 8'd1, 8'd1, 1'b1, 0, -1, 0, 1'b0);
        check_eq("t4_acc_clr", get_acc(2), 64'd1);
        check_eq("t4_ovf_clr", 64'(ovf[2]), 64'd0);
`else
        run_op(0, 8'hFF, 8'hFF, 1'b1, 0, -1, 0, 1'b0);
        check_eq("t6_acc_a", get_acc(0), 64'd1);
        run_op(0, 8'h80, 8'h7F, 1'b0, 0, -1, 0, 1'b1);
        check_eq("t6_acc_b", get_acc(0), (64'd1 << 20) - 64'd16255);
        @(negedge clk);
        check_eq("t6_single_done", 64'(done[0]), 64'd0);
`endif

        // Reset in the middle of a product discards it and clears everything.
        start[0] = 1'b1;
        clr_acc[0] = 1'b0;
        xv[0] = 8'd255;
        @(negedge clk);
        start[0] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            a_vld[0] = 1'b1;
            a_in[0]  = 2'd1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        a_vld[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("t5_busy", 64'(busy[k]), 64'd0);
            check_eq("t5_done", 64'(done[k]), 64'd0);
            check_eq("t5_acc", get_acc(k), 64'd0);
            check_eq("t5_ovf", 64'(ovf[k]), 64'd0);
            m_acc[k] = 0;
            m_ovf[k] = 1'b0;
        end
        rst = 1'b0;
        run_op(0, 8'd2, 8'd3, 1'b0, 0, -1, 0, 1'b0);
        check_eq("t5_acc_after", get_acc(0), 64'd6);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 15; i++) begin
                run_op(k, 8'($urandom), 8'($urandom), ($urandom_range(3, 0) == 0), 2, -1, 0, 1'b1);
            end
            @(negedge clk);
            check_eq("done_one_cycle", 64'(done[k]), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
